serial_word_tx: RTL and testbench
=================================

# serial_word_tx

Parallel-to-serial word transmitter producing the LSB-first bit stream consumed by the team's serial bit-stream processors (e.g. the serial two's-complement negator). It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock, LSB first. It marks the frame with framing strobes so a downstream serial FSM knows where a word starts and ends. The block sits between a parallel register/datapath and any single-bit serial consumer.

## Interface
- WIDTH, default 8: data bits per word; legal range 2..32.
- clock  input  1  single clock; all state updates on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  word to transmit; sampled only on an accepted load.
- load  input  1  request to start a word; accepted when load && ready at a posedge.
- ready  output  1  block can accept a word this cycle.
- bit_out  output  1  serial data bit, LSB first.
- frame  output  1  high for every cycle bit_out carries a frame bit.
- first_bit  output  1  high only in the cycle bit_out carries data bit 0.
- last_bit  output  1  high only in the cycle bit_out carries the final frame bit.

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with the parity macro).
- IDLE: bit_out=0, frame=0, first_bit=0, last_bit=0, ready=1.
- An accepted load in IDLE loads data_in into a WIDTH-bit shift register, clears the bit counter and moves to SHIFT.
- SHIFT: bit_out=shreg[0], frame=1. first_bit=1 when count==0. Each posedge shifts right by one and increments count.
- Last data bit is count==WIDTH-1. With no parity, this cycle has last_bit=1 and ready=1.
- After the last data bit: next state is PARITY if parity is compiled in. Otherwise it is SHIFT (new word) if load was accepted, else IDLE.
- PARITY: bit_out=even parity of the transmitted word, frame=1, last_bit=1, ready=1. Next state is SHIFT on an accepted load, else IDLE.
- Back-to-back: load accepted in the final-bit cycle starts the next word with no idle gap. first_bit of the new word directly follows last_bit of the old one.
- load while ready=0 is ignored; data_in is not sampled; the frame in flight is unaffected.
- Counter width is $clog2(WIDTH); it never wraps inside a frame.

## Timing
- Load accepted at edge k: bit n is on bit_out during the cycle after edge k+n, for n=0..WIDTH-1.
- Parity bit, if present, follows one cycle after bit WIDTH-1.
- Latency is 1 cycle from accepted load to first_bit.
- Frame length is WIDTH cycles, or WIDTH+1 with parity.
- All outputs are decoded from registered state/shift register; no combinational path from load or data_in to any output except ready (state-only).
- ready is a function of state and count only, never of load.
- Reset values: state=IDLE, shreg=0, count=0, bit_out=0, frame=0, first_bit=0, last_bit=0, ready=1.
- Reset asserted mid-frame aborts immediately and asynchronously. No partial frame resumes after release.

## Configuration
- SERIAL_TX_PARITY_EN defined: PARITY state compiled in; every frame is WIDTH+1 bits with an even parity bit appended after the MSB. last_bit moves to the parity cycle.
- SERIAL_TX_PARITY_EN undefined: no PARITY state or parity logic; frame is WIDTH bits. last_bit and ready are on the MSB cycle.

## Structure
- Shared package serial_pkg holds the tx_state_t enum (IDLE, SHIFT, PARITY) and the default width constant SERIAL_WIDTH_DEFAULT=8.
- One sub-module, tx_bit_counter, is natural. It is a parameterized up-counter with clear/enable and an is_last output.
- The shift register and FSM stay in serial_word_tx.

## Test plan
- Reset, then load 8'hA5 → bit_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles. frame high 8 cycles, first_bit on cycle 1, last_bit on cycle 8, then IDLE with ready=1.
- Parity on, load 8'hA5 then idle → 9th bit 0, last_bit on bit 9. Load 8'h07 → 9th bit 1.
- Back-to-back: load 8'hFF, then hold load with 8'h01 in the last-bit cycle → 8 ones followed immediately by 1,0,0,0,0,0,0,0 with no gap. first_bit follows last_bit.
- Load 8'h3C accepted, then pulse load with 8'hFF at bit 3 → stream stays 0,0,1,1,1,1,0,0. The 8'hFF word is never sent.
- Assert reset_L=0 at bit 4 of 8'hF0 → all outputs 0 and ready=1 immediately. After release with load=0, bit_out stays 0 and frame stays 0.
- WIDTH=2, load 2'b10 → bits 0,1. first_bit and last_bit on consecutive cycles.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial word transmitter.
//   tx_state_t           : transmitter FSM state encoding
//   SERIAL_WIDTH_DEFAULT : default data bits per word
package serial_pkg;

    localparam int SERIAL_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } tx_state_t;

endpackage

// File: rtl/tx_bit_counter.sv
// Bit position counter for serial_word_tx.
// Up-counter with synchronous clear (priority) and enable.
//   clock, reset_L : clock, async active-low reset
//   clear          : zero the count on the next edge
//   enable         : increment on the next edge
//   count          : current bit position
//   is_last        : count is at the final data bit (WIDTH-1)
module tx_bit_counter
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          is_last
);

    assign is_last = (count == CW'(WIDTH - 1));

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first, with framing strobes.
//   clock, reset_L : clock, async active-low reset
//   data_in        : word to send, sampled on an accepted load
//   load / ready   : load handshake, accepted when both high at a posedge
//   bit_out        : serial data bit
//   frame          : bit_out carries a frame bit
//   first_bit      : bit_out carries data bit 0
//   last_bit       : bit_out carries the final frame bit
// Build option: define SERIAL_TX_PARITY_EN to append an even parity bit.
//
// state  | meaning
// IDLE   | no frame in flight, waiting for load
// SHIFT  | data bits on bit_out, one per clock
// PARITY | even parity bit on bit_out (parity builds only)
module serial_word_tx
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             bit_out,
    output logic             frame,
    output logic             first_bit,
    output logic             last_bit
);

    localparam int CW = $clog2(WIDTH);

    tx_state_t        state;
    tx_state_t        next_state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;
    logic             is_last;
    logic             accept;
    logic             cnt_clear;
    logic             cnt_en;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity_q;
`endif

    // ready depends only on state/count, so there is no path from load.
`ifdef SERIAL_TX_PARITY_EN
    assign ready = (state == IDLE) || (state == PARITY);
`else
    assign ready = (state == IDLE) || ((state == SHIFT) && is_last);
`endif

    assign accept = load && ready;

    // Clearing at the last data bit keeps the counter from wrapping.
    assign cnt_clear = accept || ((state == SHIFT) && is_last);
    assign cnt_en    = (state == SHIFT);

    tx_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_counter (
        .clock   (clock),
        .reset_L (reset_L),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .count   (count),
        .is_last (is_last)
    );

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= data_in;
        end else if (state == SHIFT) begin
            shreg <= shreg >> 1;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Parity of the whole word is captured up front, not accumulated.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^data_in;
        end
    end
`endif

    always_comb begin
        next_state = state;
        bit_out    = 1'b0;
        frame      = 1'b0;
        first_bit  = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) next_state = SHIFT;
            end
            SHIFT: begin
                bit_out   = shreg[0];
                frame     = 1'b1;
                first_bit = (count == '0);
                if (is_last) begin
`ifdef SERIAL_TX_PARITY_EN
                    next_state = PARITY;
`else
                    last_bit   = 1'b1;
                    next_state = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                bit_out    = parity_q;
                frame      = 1'b1;
                last_bit   = 1'b1;
                next_state = accept ? SHIFT : IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed self-checking bench for serial_word_tx (WIDTH=8 and WIDTH=2).
// Follows SERIAL_TX_PARITY_EN to pick the expected frame shape.
module tb_serial_word_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clock;
    logic       reset_L;
    logic [7:0] data_in;
    logic       load;
    logic       ready, bit_out, frame, first_bit, last_bit;

    logic [1:0] data2;
    logic       load2;
    logic       ready2, bit2, frame2, first2, last2;

    int n_compared   = 0;
    int n_mismatched = 0;

    serial_word_tx #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .load      (load),
        .ready     (ready),
        .bit_out   (bit_out),
        .frame     (frame),
        .first_bit (first_bit),
        .last_bit  (last_bit)
    );

    serial_word_tx #(.WIDTH(2)) dut2 (
        .clock     (clock),
        .reset_L   (reset_L),
        .data_in   (data2),
        .load      (load2),
        .ready     (ready2),
        .bit_out   (bit2),
        .frame     (frame2),
        .first_bit (first2),
        .last_bit  (last2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic b, input logic f,
                              input logic fb, input logic lb, input logic r);
        check_val({tag, "_bit"},   32'(bit_out),   32'(b));
        check_val({tag, "_frame"}, 32'(frame),     32'(f));
        check_val({tag, "_first"}, 32'(first_bit), 32'(fb));
        check_val({tag, "_last"},  32'(last_bit),  32'(lb));
        check_val({tag, "_ready"}, 32'(ready),     32'(r));
    endtask

    // Checks one 8-bit frame already accepted. Optionally pulses a load
    // with 8'hFF at data bit intrude_at, and optionally chains next_w
    // into the final frame cycle.
    task automatic check_frame(input string tag, input logic [7:0] w, input logic par_bit,
                               input int intrude_at, input logic chain, input logic [7:0] next_w);
        for (int n = 0; n < 8; n++) begin
            check_outs($sformatf("%s_b%0d", tag, n), w[n], 1'b1, n == 0,
                       (n == 7) && !PAR, (n == 7) && !PAR);
            if (n == intrude_at) begin
                load    = 1'b1;
                data_in = 8'hFF;
            end else if (n == 7 && !PAR && chain) begin
                load    = 1'b1;
                data_in = next_w;
            end else begin
                load = 1'b0;
            end
            step();
        end
        if (PAR) begin
            check_outs({tag, "_par"}, par_bit, 1'b1, 1'b0, 1'b1, 1'b1);
            load    = chain;
            data_in = next_w;
            step();
        end
        load = 1'b0;
    endtask

    task automatic start_word(input logic [7:0] w);
        load    = 1'b1;
        data_in = w;
        step();
        load = 1'b0;
    endtask

    initial begin
        reset_L = 1'b0;
        load    = 1'b0;
        data_in = 8'h00;
        load2   = 1'b0;
        data2   = 2'b00;
        #2;
        check_outs("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #10 reset_L = 1'b1;
        step();
        check_outs("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // A5 -> 1,0,1,0,0,1,0,1 then idle
        start_word(8'hA5);
        check_frame("a5", 8'hA5, 1'b0, -1, 1'b0, 8'h00);
        check_outs("a5_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();

        // 07: parity bit 1 in parity builds
        start_word(8'h07);
        check_frame("w07", 8'h07, 1'b1, -1, 1'b0, 8'h00);
        check_outs("w07_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back FF then 01 with no gap
        start_word(8'hFF);
        check_frame("ff", 8'hFF, 1'b0, -1, 1'b1, 8'h01);
        check_frame("b2b01", 8'h01, 1'b1, -1, 1'b0, 8'h00);
        check_outs("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();

        // 3C with a load pulse of FF at bit 3 that must be ignored
        start_word(8'h3C);
        check_frame("w3c", 8'h3C, 1'b0, 3, 1'b0, 8'h00);
        check_outs("w3c_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check_outs("w3c_idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // F0 aborted by reset at bit 4
        start_word(8'hF0);
        for (int n = 0; n < 4; n++) begin
            check_val($sformatf("f0_b%0d", n), 32'(bit_out), 32'(n >= 4));
            step();
        end
        check_outs("f0_b4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 reset_L = 1'b0;
        #1;
        check_outs("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        reset_L = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            check_outs($sformatf("post_rst%0d", n), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // WIDTH=2: 2'b10 -> bits 0,1
        load2 = 1'b1;
        data2 = 2'b10;
        step();
        load2 = 1'b0;
        check_val("w2_b0_bit",   32'(bit2),   32'd0);
        check_val("w2_b0_first", 32'(first2), 32'd1);
        check_val("w2_b0_last",  32'(last2),  32'd0);
        check_val("w2_b0_ready", 32'(ready2), 32'd0);
        step();
        check_val("w2_b1_bit",   32'(bit2),   32'd1);
        check_val("w2_b1_first", 32'(first2), 32'd0);
        check_val("w2_b1_last",  32'(last2),  32'(!PAR));
        check_val("w2_b1_frame", 32'(frame2), 32'd1);
        step();
        if (PAR) begin
            check_val("w2_par_bit",  32'(bit2),  32'd1);
            check_val("w2_par_last", 32'(last2), 32'd1);
            step();
        end
        check_val("w2_idle_frame", 32'(frame2), 32'd0);
        check_val("w2_idle_ready", 32'(ready2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
